// File: rtl/dp_sequencer.sv
// dp_sequencer: multi-cycle fetch/decode/execute controller for the 16x16 register-file datapath.
// Latency: 2 cycles per ALU/ALUI/branch/JMP/NOP, 3 for ST and 4 for LD, plus memory wait cycles.
// Backpressure: each request is held until its ack arrives. Acks outside FETCH/MEM are ignored.
//
// Ports:
//   clk, rst_n                     clock and synchronous active-low reset
//   start                          leave IDLE (sampled in IDLE only)
//   imem_req/addr/ack/rdata        instruction fetch handshake; addr is pc
//   dmem_req/we/addr/wdata/ack/rdata  data handshake; addr = busa, wdata = busb
//   busa, busb, z, n               datapath operand buses and flags
//   control, constant, data        datapath control word, constant and load data
//   pc, halted                     program counter and HALT indicator
module dp_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [15:0] dmem_rdata,
  input  logic [15:0] busa,
  input  logic [15:0] busb,
  input  logic        z,
  input  logic        n,
  output logic [25:0] control,
  output logic [15:0] constant,
  output logic [15:0] data,
  output logic [15:0] pc,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [3:0] OP_ALU  = 4'h1;
  localparam logic [3:0] OP_ALUI = 4'h2;
  localparam logic [3:0] OP_LD   = 4'h3;
  localparam logic [3:0] OP_ST   = 4'h4;
  localparam logic [3:0] OP_BZ   = 4'h5;
  localparam logic [3:0] OP_BN   = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t      state, state_nxt;
  logic [31:0] ir;
  logic [15:0] pc_nxt;
  logic        ir_ld;
  logic        data_ld;

  logic [3:0]  op, da, aa, ba;
  logic [15:0] imm;

  assign op  = ir[31:28];
  assign da  = ir[27:24];
  assign aa  = ir[23:20];
  assign ba  = ir[19:16];
  assign imm = ir[15:0];

  assign imem_addr = pc;

  // control = {DA[25:22], AA[21:18], BA[17:14], MB[13], FS[12:9], SS[8:6], SA[5:2], MD[1], RW[0]}
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    ir_ld      = 1'b0;
    data_ld    = 1'b0;
    control    = 26'b0;
    constant   = 16'h0000;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = 16'h0000;
    dmem_wdata = 16'h0000;
    halted     = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_FETCH;
      end

      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_ld     = 1'b1;
          pc_nxt    = pc + 16'd1;
          state_nxt = S_EXEC;
        end
      end

      S_EXEC: begin
        state_nxt = S_FETCH;
        case (op)
          OP_ALU: begin
            control = {da, aa, ba, 1'b0, imm[3:0], imm[6:4], imm[10:7], 1'b0, 1'b1};
          end
          OP_ALUI: begin
            // The ba field carries the function select for immediate ops.
            control  = {da, aa, 4'd0, 1'b1, ba, 3'b111, 4'd0, 1'b0, 1'b1};
            constant = imm;
          end
          OP_LD, OP_ST: begin
            state_nxt = S_MEM;
          end
          OP_BZ, OP_BN: begin
            // FS=0000 passes A through so the datapath flags reflect register aa.
            control = {4'd0, aa, 4'd0, 1'b0, 4'd0, 3'd0, 4'd0, 1'b0, 1'b0};
            // pc already points past the branch; imm is the full 16-bit signed offset.
            if ((op == OP_BZ && z) || (op == OP_BN && n)) pc_nxt = pc + imm;
          end
          OP_JMP: begin
            pc_nxt = imm;
          end
          OP_HALT: begin
            state_nxt = S_HALT;
          end
          default: ;
        endcase
      end

      S_MEM: begin
        control    = {4'd0, aa, ba, 1'b0, 4'd0, 3'b111, 4'd0, 1'b0, 1'b0};
        dmem_req   = 1'b1;
        dmem_we    = (op == OP_ST);
        dmem_addr  = busa;
        dmem_wdata = busb;
        if (dmem_ack) begin
          if (op == OP_ST) begin
            state_nxt = S_FETCH;
          end else begin
            data_ld   = 1'b1;
            state_nxt = S_WB;
          end
        end
      end

      S_WB: begin
        control   = {da, 4'd0, 4'd0, 1'b0, 4'd0, 3'd0, 4'd0, 1'b1, 1'b1};
        state_nxt = S_FETCH;
      end

      S_HALT: begin
        halted = 1'b1;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pc    <= RESET_PC;
      ir    <= 32'h0;
      data  <= 16'h0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (ir_ld)   ir   <= imem_rdata;
      if (data_ld) data <= dmem_rdata;
    end
  end

endmodule

// File: tb/tb_dp_sequencer.sv
// tb_dp_sequencer: drives dp_sequencer as instruction/data memory and datapath, checking each cycle.
// Latency: the bench follows instruction timing cycle by cycle; all waits are fixed cycle counts.
// Backpressure: memory acks are delayed by random or directed wait counts.
module tb_dp_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_ack;
  logic [15:0] dmem_rdata;
  logic [15:0] busa;
  logic [15:0] busb;
  logic        z;
  logic        n;
  logic [25:0] control;
  logic [15:0] constant;
  logic [15:0] data;
  logic [15:0] pc;
  logic        halted;

  dp_sequencer #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .busa(busa), .busb(busb), .z(z), .n(n),
    .control(control), .constant(constant), .data(data), .pc(pc), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference architectural state: program counter and last loaded value.
  logic [15:0] m_pc;
  logic [15:0] m_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Control word expected during the execute cycle, assembled field by field.
  function automatic logic [25:0] exec_ctl(input logic [31:0] ins);
    logic [3:0]  op, f_da, f_aa, f_ba;
    logic [15:0] f_imm;
    op = ins[31:28]; f_da = ins[27:24]; f_aa = ins[23:20]; f_ba = ins[19:16]; f_imm = ins[15:0];
    case (op)
      4'h1: return {f_da, f_aa, f_ba, 1'b0, f_imm[3:0], f_imm[6:4], f_imm[10:7], 1'b0, 1'b1};
      4'h2: return {f_da, f_aa, 4'd0, 1'b1, f_ba, 3'b111, 4'd0, 1'b0, 1'b1};
      4'h5, 4'h6: return {4'd0, f_aa, 22'd0} >> 4;
      default: return 26'd0;
    endcase
  endfunction

  function automatic logic [25:0] mem_ctl(input logic [31:0] ins);
    return {4'd0, ins[23:20], ins[19:16], 1'b0, 4'd0, 3'b111, 4'd0, 2'b00};
  endfunction

  function automatic logic [25:0] wb_ctl(input logic [31:0] ins);
    return {ins[27:24], 20'd0, 2'b11};
  endfunction

  task automatic mem_cycle_checks(input logic [31:0] ins);
    chk("mem_req", dmem_req, 1);
    chk("mem_we", dmem_we, ins[31:28] == 4'h4);
    chk("mem_addr", dmem_addr, busa);
    chk("mem_wdata", dmem_wdata, busb);
    chk("mem_ctl", control, mem_ctl(ins));
    chk("mem_imem_req", imem_req, 0);
  endtask

  // Runs one instruction from its first FETCH cycle to the next FETCH cycle.
  // Entered and left at a negedge with the DUT in FETCH.
  task automatic run_instr(input logic [31:0] ins, input int flat, input int mlat,
                           input logic zz, input logic nn,
                           input logic [15:0] a_v, input logic [15:0] b_v, input logic [15:0] rd);
    logic [3:0] op;
    op = ins[31:28];
    chk("fetch_req", imem_req, 1);
    chk("fetch_addr", imem_addr, m_pc);
    chk("data_hold", data, m_data);
    for (int i = 0; i < flat; i++) begin
      chk("fetch_ctl", control, 0);
      @(negedge clk);
      chk("fetch_wait_req", imem_req, 1);
    end
    imem_ack = 1'b1; imem_rdata = ins;
    z = zz; n = nn; busa = a_v; busb = b_v;
    @(negedge clk);
    imem_ack = 1'b0; imem_rdata = $urandom;
    m_pc = m_pc + 16'd1;

    chk("exec_ctl", control, exec_ctl(ins));
    chk("exec_const", constant, (op == 4'h2) ? ins[15:0] : 16'h0);
    chk("exec_reqs", {imem_req, dmem_req}, 0);
    chk("exec_pc", pc, m_pc);
    if ((op == 4'h5 && zz) || (op == 4'h6 && nn)) m_pc = m_pc + ins[15:0];
    if (op == 4'h7) m_pc = ins[15:0];

    if (op == 4'hF) begin
      @(negedge clk);
      chk("halt_flag", halted, 1);
      chk("halt_req", imem_req, 0);
    end else begin
      if (op == 4'h3 || op == 4'h4) begin
        @(negedge clk);
        for (int i = 0; i < mlat; i++) begin
          mem_cycle_checks(ins);
          @(negedge clk);
        end
        mem_cycle_checks(ins);
        dmem_ack = 1'b1; dmem_rdata = rd;
        @(negedge clk);
        dmem_ack = 1'b0; dmem_rdata = $urandom;
        if (op == 4'h3) begin
          m_data = rd;
          chk("wb_ctl", control, wb_ctl(ins));
          chk("wb_data", data, rd);
          @(negedge clk);
        end
      end else begin
        @(negedge clk);
      end
      chk("next_pc", pc, m_pc);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_imem_req"}, imem_req, 0);
    chk({tag, "_dmem_req"}, {dmem_req, dmem_we}, 0);
    chk({tag, "_ctl"}, control, 0);
    chk({tag, "_pc"}, pc, 16'h0000);
    chk({tag, "_halted"}, halted, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    dmem_ack = 1'b0; dmem_rdata = 16'h0;
    busa = 16'h0; busb = 16'h0; z = 1'b0; n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    chk("reset_data", data, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("idle_hold");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_pc = 16'h0000; m_data = 16'h0000;

    // Directed cases
    run_instr({4'h2, 4'd1, 4'd0, 4'b0010, 16'h0005}, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
    chk("alui_pc", pc, 16'd1);
    run_instr({4'h1, 4'd3, 4'd1, 4'd2, 16'h0092}, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0);
    run_instr({4'h3, 4'd4, 4'd1, 4'd0, 16'h0000}, 0, 3, 0, 0, 16'h0040, 16'h7777, 16'hBEEF);
    chk("ld_data", data, 16'hBEEF);
    run_instr({4'h4, 4'd0, 4'd2, 4'd5, 16'h0000}, 2, 2, 0, 0, 16'h0010, 16'h1234, 16'hAAAA);
    chk("st_data_kept", data, 16'hBEEF);
    run_instr({4'h7, 12'h000, 16'd10}, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
    run_instr({4'h5, 12'h000, 16'hFFFB}, 0, 0, 1, 0, 16'h0, 16'h0, 16'h0);
    chk("bz_taken_pc", pc, 16'd6);
    run_instr({4'h7, 12'h000, 16'd10}, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
    run_instr({4'h5, 12'h000, 16'hFFFB}, 0, 0, 0, 1, 16'h0, 16'h0, 16'h0);
    chk("bz_not_taken_pc", pc, 16'd11);
    run_instr({4'h6, 12'h000, 16'h0010}, 0, 0, 0, 1, 16'h0, 16'h0, 16'h0);
    chk("bn_taken_pc", pc, 16'd28);
    run_instr({4'h7, 12'h000, 16'hFFFF}, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
    run_instr({4'h0, 28'h0}, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
    chk("pc_wrap", pc, 16'h0000);

    // Randomized instruction stream (HALT excluded)
    for (int k = 0; k < 200; k++) begin
      logic [31:0] ins;
      ins = $urandom;
      ins[31:28] = 4'($urandom_range(0, 14));
      run_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    end

    // Reset while an ack is present in FETCH
    imem_ack = 1'b1; imem_rdata = 32'h2123_4567;
    rst_n = 1'b0;
    @(negedge clk);
    imem_ack = 1'b0;
    check_idle("rst_fetch");
    chk("rst_fetch_data", data, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_fetch_stay_idle", imem_req, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_pc = 16'h0000; m_data = 16'h0000;

    // HALT is sticky through start pulses until reset
    run_instr({4'hF, 28'h0}, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0);
    for (int k = 0; k < 3; k++) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("halt_sticky", halted, 1);
      chk("halt_no_fetch", imem_req, 0);
      chk("halt_ctl", control, 0);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("halt_reset", halted, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
